// File: rtl/snn_window_scheduler.sv
// snn_window_scheduler
// Runs one classification window for the spiking network. It clears the output
// neurons, then drives the encode and integrate phases. During those phases it
// counts out_spike pulses for each class. It then scans the counts for the
// winner and holds the result until the consumer acknowledges it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, all outputs low
// CLEAR     | one-cycle neuron clear, counters zeroed, window timer loaded
// ENCODE    | input and exc neurons enabled, spikes counted
// INTEGRATE | exc neurons enabled only, spikes counted
// DECIDE    | argmax scan, one counter per cycle
// HOLD      | result_valid high until result_ack
module snn_window_scheduler #(
    parameter int N_OUT       = 4,
    parameter int ENCODE_TIME = 23,
    parameter int T_WINDOW    = 250,
    parameter int CNT_W       = 8,
    parameter int CLS_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] out_spikes,
    output logic             neuron_clr,
    output logic             neuron_en,
    output logic             enc_en,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CLS_W-1:0] result_class,
    output logic [CNT_W-1:0] result_count,
    output logic             result_none
);

    localparam int TMR_W = $clog2(T_WINDOW + 1);
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // The timer is loaded with T_WINDOW-1 in CLEAR, so it holds T_WINDOW-1 in the
    // first ENCODE cycle and reaches 0 in the last INTEGRATE cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(T_WINDOW - 1);
    localparam logic [TMR_W-1:0] TMR_ENC_END = TMR_W'(T_WINDOW - ENCODE_TIME);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ENCODE,
        S_INTEGRATE,
        S_DECIDE,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [IDX_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  spike_cnt [N_OUT];
    logic [CNT_W-1:0]  best_cnt;
    logic [CLS_W-1:0]  best_cls;
    logic [CNT_W-1:0]  cand_cnt;
    logic              cand_better;
    logic              counting;
    logic              scan_last;

    assign counting    = (state == S_ENCODE) || (state == S_INTEGRATE);
    assign scan_last   = (scan_idx == IDX_LAST);
    assign cand_cnt    = spike_cnt[scan_idx];
    // A strict compare keeps the earlier (lower) index on a tie.
    assign cand_better = (cand_cnt > best_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = S_ENCODE;
            S_ENCODE:    if (timer == TMR_ENC_END) state_nxt = S_INTEGRATE;
            S_INTEGRATE: if (timer == '0) state_nxt = S_DECIDE;
            S_DECIDE:    if (scan_last) state_nxt = S_HOLD;
            S_HOLD: begin
                if (result_ack) state_nxt = start ? S_CLEAR : S_IDLE;
            end
            default:     state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    // Registered control outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            neuron_clr   <= 1'b0;
            neuron_en    <= 1'b0;
            enc_en       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            neuron_clr   <= (state_nxt == S_CLEAR);
            neuron_en    <= (state_nxt == S_ENCODE) || (state_nxt == S_INTEGRATE);
            enc_en       <= (state_nxt == S_ENCODE);
            busy         <= (state_nxt != S_IDLE);
            result_valid <= (state_nxt == S_HOLD);
        end
    end

    // Window down-counter; its length does not depend on the spike input
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == S_CLEAR) begin
            timer <= TMR_LOAD;
        end else if (counting && (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    // Saturating per-class spike counters, active only in ENCODE/INTEGRATE
    always_ff @(posedge clk) begin
        if (rst || (state == S_CLEAR)) begin
            for (int i = 0; i < N_OUT; i++) spike_cnt[i] <= '0;
        end else if (counting) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (out_spikes[i] && (spike_cnt[i] != {CNT_W{1'b1}})) begin
                    spike_cnt[i] <= spike_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Argmax scan: one counter per DECIDE cycle
    always_ff @(posedge clk) begin
        if (rst || (state == S_CLEAR)) begin
            scan_idx <= '0;
            best_cnt <= '0;
            best_cls <= '0;
        end else if (state == S_DECIDE) begin
            if (!scan_last) scan_idx <= scan_idx + 1'b1;
            if (cand_better) begin
                best_cnt <= cand_cnt;
                best_cls <= CLS_W'(scan_idx);
            end
        end
    end

    // Result fields are captured once, on the last scan step, so they stay stable in HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            result_class <= '0;
            result_count <= '0;
            result_none  <= 1'b0;
        end else if ((state == S_DECIDE) && scan_last && !abort) begin
            result_class <= cand_better ? CLS_W'(scan_idx) : best_cls;
            result_count <= cand_better ? cand_cnt : best_cnt;
            result_none  <= cand_better ? (cand_cnt == '0) : (best_cnt == '0);
        end
    end

endmodule

// File: tb/tb_snn_window_scheduler.sv
// Bench for snn_window_scheduler: an instance with CNT_W=4 and an instance with
// CNT_W=3 share the same stimulus. A reference model pushes the expected results
// to per-instance queues. The queues are popped when result_valid rises.
module tb_snn_window_scheduler;

    localparam int N_OUT = 4;
    localparam int ENC   = 3;
    localparam int TW    = 10;
    localparam int RISE  = TW + N_OUT + 2;

    typedef struct {
        int cls;
        int cnt;
        bit none;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       result_ack;
    logic [3:0] out_spikes;

    logic       a_clr, a_en, a_enc, a_busy, a_valid, a_none;
    logic [1:0] a_cls;
    logic [3:0] a_cnt;
    logic       b_clr, b_en, b_enc, b_busy, b_valid, b_none;
    logic [1:0] b_cls;
    logic [2:0] b_cnt;

    snn_window_scheduler #(.N_OUT(N_OUT), .ENCODE_TIME(ENC), .T_WINDOW(TW), .CNT_W(4), .CLS_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_spikes(out_spikes),
        .neuron_clr(a_clr), .neuron_en(a_en), .enc_en(a_enc), .busy(a_busy),
        .result_valid(a_valid), .result_ack(result_ack), .result_class(a_cls),
        .result_count(a_cnt), .result_none(a_none)
    );

    snn_window_scheduler #(.N_OUT(N_OUT), .ENCODE_TIME(ENC), .T_WINDOW(TW), .CNT_W(3), .CLS_W(2)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_spikes(out_spikes),
        .neuron_clr(b_clr), .neuron_en(b_en), .enc_en(b_enc), .busy(b_busy),
        .result_valid(b_valid), .result_ack(result_ack), .result_class(b_cls),
        .result_count(b_cnt), .result_none(b_none)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t sb3[$];
    logic [3:0] pat [0:39];
    int   start_pulse;
    bit   log_clr [0:39];
    bit   log_enc [0:39];
    bit   log_en  [0:39];
    int   rise_cycle;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat();
        for (int c = 0; c < 40; c++) pat[c] = '0;
        start_pulse = -1;
    endtask

    task automatic model(input int sat, output exp_t e);
        int cnt [4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 2; c <= TW + 1; c++)
            for (int i = 0; i < 4; i++)
                if (pat[c][i] && cnt[i] < sat) cnt[i]++;
        e.cls = 0;
        e.cnt = 0;
        for (int i = 0; i < 4; i++)
            if (cnt[i] > e.cnt) begin
                e.cls = i;
                e.cnt = cnt[i];
            end
        e.none = (e.cnt == 0);
    endtask

    // Entry is cycle 0 of a window: start is raised here. The caller may already
    // have raised result_ack for a back-to-back restart from HOLD.
    task automatic run_window(input bit b2b);
        exp_t e, e3, g, g3;
        int c;
        model(15, e);
        sb.push_back(e);
        model(7, e3);
        sb3.push_back(e3);
        start = 1'b1;
        out_spikes = pat[0];
        rise_cycle = -1;
        c = 0;
        while (c < 39) begin
            tick();
            c++;
            start = (c == start_pulse);
            result_ack = 1'b0;
            out_spikes = pat[c];
            log_clr[c] = a_clr;
            log_enc[c] = a_enc;
            log_en[c]  = a_en;
            if (a_valid) begin
                rise_cycle = c;
                break;
            end
        end
        start = 1'b0;
        out_spikes = '0;
        n_cmp++;
        if (log_clr[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_cycle1: neuron_clr=%0b want 1", log_clr[1]);
        end
        n_cmp++;
        if (rise_cycle != RISE) begin
            n_bad++;
            $display("FAIL valid_latency: rose at cycle %0d want %0d", rise_cycle, RISE);
        end
        if (rise_cycle < 0) return;
        g  = sb.pop_front();
        g3 = sb3.pop_front();
        n_cmp++;
        if (a_cls !== 2'(g.cls) || a_cnt !== 4'(g.cnt) || a_none !== g.none) begin
            n_bad++;
            $display("FAIL result: cls=%0d cnt=%0d none=%0b want cls=%0d cnt=%0d none=%0b",
                     a_cls, a_cnt, a_none, g.cls, g.cnt, g.none);
        end
        n_cmp++;
        if (b_valid !== 1'b1 || b_cls !== 2'(g3.cls) || b_cnt !== 3'(g3.cnt) || b_none !== g3.none) begin
            n_bad++;
            $display("FAIL result_cnt3: v=%0b cls=%0d cnt=%0d none=%0b want cls=%0d cnt=%0d none=%0b",
                     b_valid, b_cls, b_cnt, b_none, g3.cls, g3.cnt, g3.none);
        end
        tick();
        n_cmp++;
        if (a_valid !== 1'b1 || a_cls !== 2'(g.cls) || a_cnt !== 4'(g.cnt)) begin
            n_bad++;
            $display("FAIL hold_stable: v=%0b cls=%0d cnt=%0d want v=1 cls=%0d cnt=%0d",
                     a_valid, a_cls, a_cnt, g.cls, g.cnt);
        end
        if (!b2b) begin
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            n_cmp++;
            if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL ack_idle: valid=%0b busy=%0b want 0 0", a_valid, a_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; result_ack = 1'b0; out_spikes = '0;
        clear_pat();
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++;
        if ({a_clr, a_en, a_enc, a_busy, a_valid, a_none, a_cls, a_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: %b want all 0",
                     {a_clr, a_en, a_enc, a_busy, a_valid, a_none, a_cls, a_cnt});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        n_cmp++;
        if (a_busy !== 1'b0 || a_clr !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_idle: busy=%0b clr=%0b want 0 0", a_busy, a_clr);
        end
    endtask

    task automatic test_timing();
        int bad;
        clear_pat();
        run_window(0);
        bad = 0;
        for (int c = 1; c <= RISE; c++) begin
            n_cmp++;
            if (log_clr[c] !== (c == 1) || log_enc[c] !== (c >= 2 && c <= ENC + 1) ||
                log_en[c] !== (c >= 2 && c <= TW + 1)) begin
                n_bad++;
                $display("FAIL phase_timing: cycle %0d clr=%0b enc=%0b en=%0b want %0b %0b %0b",
                         c, log_clr[c], log_enc[c], log_en[c],
                         (c == 1), (c >= 2 && c <= ENC + 1), (c >= 2 && c <= TW + 1));
            end
        end
    endtask

    task automatic test_argmax();
        clear_pat();
        for (int k = 0; k < 5; k++) pat[2 + 2 * k][2] = 1'b1;
        for (int k = 0; k < 3; k++) pat[3 + 2 * k][1] = 1'b1;
        run_window(0);
    endtask

    task automatic test_tie_outside();
        clear_pat();
        for (int c = 2; c <= 5; c++) pat[c][1] = 1'b1;
        for (int c = 6; c <= 9; c++) pat[c][3] = 1'b1;
        pat[1][0]  = 1'b1;
        pat[12][0] = 1'b1;
        run_window(0);
    endtask

    task automatic test_saturate();
        clear_pat();
        for (int c = 0; c <= 20; c++) pat[c][0] = 1'b1;
        run_window(0);
    endtask

    task automatic test_back_to_back();
        clear_pat();
        run_window(1);
        clear_pat();
        pat[5][3]  = 1'b1;
        pat[11][3] = 1'b1;
        pat[7][2]  = 1'b1;
        result_ack = 1'b1;
        run_window(0);
    endtask

    task automatic cancel_at_6(input bit use_rst);
        bit seen;
        start = 1'b1;
        out_spikes = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        tick();
        rst = 1'b0;
        abort = 1'b0;
        out_spikes = '0;
        n_cmp++;
        if (a_busy !== 1'b0 || a_en !== 1'b0 || a_enc !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_idle(rst=%0b): busy=%0b en=%0b enc=%0b want 0 0 0",
                     use_rst, a_busy, a_en, a_enc);
        end
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (a_valid || b_valid || a_busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_no_result(rst=%0b): activity seen=1 want 0", use_rst);
        end
    endtask

    task automatic test_abort();
        cancel_at_6(0);
        cancel_at_6(1);
        clear_pat();
        pat[4][3] = 1'b1;
        pat[9][3] = 1'b1;
        pat[6][0] = 1'b1;
        start_pulse = 8;
        run_window(0);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_argmax();
        test_tie_outside();
        test_saturate();
        test_back_to_back();
        test_abort();
        n_cmp++;
        if (sb.size() != 0 || sb3.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d/%0d left want 0", sb.size(), sb3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
